// File: rtl/vga_sink_monitor_if.sv
// VGA video bus as produced by the sync generator:
// sync pulses, blanking flag and 8-bit colour.
interface vga_sink_monitor_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (output hsync, vsync, video_on, red, green, blue);
    modport slave  (input  hsync, vsync, video_on, red, green, blue);
endinterface

// File: rtl/vga_sink_monitor.sv
// Passive VGA receiver: recovers pixel coordinates, checks line/frame
// timing, accumulates a per-frame checksum and reports lock status.
module vga_sink_monitor #(
    parameter int H_ACTIVE  = 1024,
    parameter int V_ACTIVE  = 768,
    parameter int H_TOTAL   = 1328,
    parameter int V_TOTAL   = 806,
    parameter bit HS_ACTIVE = 1'b0,
    parameter bit VS_ACTIVE = 1'b0
) (
    input  logic              sys_clock,
    input  logic              rst,
    vga_sink_monitor_if.slave vga,
    output logic              rx_valid,
    output logic [10:0]       rx_x,
    output logic [10:0]       rx_y,
    output logic [7:0]        rx_r,
    output logic [7:0]        rx_g,
    output logic [7:0]        rx_b,
    output logic              frame_done,
    output logic [15:0]       frame_checksum,
    output logic [10:0]       active_lines,
    output logic [15:0]       frame_count,
    output logic              locked,
    output logic              err_hlen,
    output logic              err_vlen,
    output logic              err_active
);
    localparam logic [15:0] H_TOT = 16'(H_TOTAL);
    localparam logic [15:0] V_TOT = 16'(V_TOTAL);
    localparam logic [15:0] H_ACT = 16'(H_ACTIVE);
    localparam logic [10:0] V_ACT = 11'(V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  good;
    logic [1:0]  good_nxt;

    logic        hs_prev;
    logic        vs_prev;
    logic        vo_prev;
    logic [15:0] h_cnt;
    logic        h_seen;
    logic [15:0] v_cnt;
    logic [15:0] w_cnt;
    logic [10:0] y_cnt;
    logic [15:0] sum_acc;

    logic        hs_now;
    logic        vs_now;
    logic        hs_edge;
    logic        vs_edge;
    logic        vo_fall;
    logic        checking;
    logic [15:0] pix_sum;
    logic [15:0] sum_nxt;
    logic [10:0] lines_nxt;
    logic [15:0] v_nxt;
    logic [10:0] x_cur;
    logic        hlen_bad;
    logic        vlen_bad;
    logic        wid_bad;
    logic        cnt_bad;
    logic        any_bad;

    assign hs_now   = (vga.hsync == HS_ACTIVE);
    assign vs_now   = (vga.vsync == VS_ACTIVE);
    assign hs_edge  = hs_now & ~hs_prev;
    assign vs_edge  = vs_now & ~vs_prev;
    assign vo_fall  = ~vga.video_on & vo_prev;
    assign checking = (state != SEARCH);

    assign pix_sum = 16'(vga.red) + 16'(vga.green) + 16'(vga.blue);
    assign sum_nxt = sum_acc + (vga.video_on ? pix_sum : 16'd0);

    assign lines_nxt = (vo_fall && y_cnt != 11'h7ff) ? y_cnt + 11'd1 : y_cnt;

    // An hsync edge coinciding with vsync belongs to the ending frame.
    assign v_nxt = (hs_edge && v_cnt != 16'hffff) ? v_cnt + 16'd1 : v_cnt;

    assign x_cur = !vo_prev ? 11'd0 :
                   (w_cnt > 16'd2047) ? 11'h7ff : w_cnt[10:0];

    assign hlen_bad = checking & hs_edge & h_seen & (h_cnt != H_TOT);
    assign vlen_bad = checking & vs_edge & (v_nxt != V_TOT);
    assign wid_bad  = checking & vo_fall & (w_cnt != H_ACT);
    assign cnt_bad  = checking & vs_edge & (lines_nxt != V_ACT);
    assign any_bad  = hlen_bad | vlen_bad | wid_bad | cnt_bad;

    always_ff @(posedge sys_clock) begin
        if (rst) begin
            state  <= SEARCH;
            good   <= 2'd0;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            good   <= good_nxt;
            locked <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        if (any_bad) begin
            state_nxt = SEARCH;
            good_nxt  = 2'd0;
        end else if (vs_edge) begin
            unique case (state)
                SEARCH: state_nxt = MEASURE;
                MEASURE: begin
                    good_nxt = (good == 2'd3) ? good : good + 2'd1;
                    if (good_nxt >= 2'd2)
                        state_nxt = LOCKED;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Sync history resets to "asserted" so a pulse already in
    // progress at reset release is not taken as a leading edge.
    always_ff @(posedge sys_clock) begin
        if (rst) begin
            hs_prev        <= 1'b1;
            vs_prev        <= 1'b1;
            vo_prev        <= 1'b0;
            h_cnt          <= 16'd0;
            h_seen         <= 1'b0;
            v_cnt          <= 16'd0;
            w_cnt          <= 16'd0;
            y_cnt          <= 11'd0;
            sum_acc        <= 16'd0;
            rx_valid       <= 1'b0;
            rx_x           <= 11'd0;
            rx_y           <= 11'd0;
            rx_r           <= 8'd0;
            rx_g           <= 8'd0;
            rx_b           <= 8'd0;
            frame_done     <= 1'b0;
            frame_checksum <= 16'd0;
            active_lines   <= 11'd0;
            frame_count    <= 16'd0;
            err_hlen       <= 1'b0;
            err_vlen       <= 1'b0;
            err_active     <= 1'b0;
        end else begin
            hs_prev <= hs_now;
            vs_prev <= vs_now;
            vo_prev <= vga.video_on;

            if (hs_edge)
                h_cnt <= 16'd1;
            else if (h_cnt != 16'hffff)
                h_cnt <= h_cnt + 16'd1;
            h_seen <= h_seen | hs_edge;

            if (vga.video_on) begin
                if (!vo_prev)
                    w_cnt <= 16'd1;
                else if (w_cnt != 16'hffff)
                    w_cnt <= w_cnt + 16'd1;
            end

            v_cnt   <= vs_edge ? 16'd0 : v_nxt;
            y_cnt   <= vs_edge ? 11'd0 : lines_nxt;
            sum_acc <= vs_edge ? 16'd0 : sum_nxt;

            rx_valid <= vga.video_on;
            rx_x     <= x_cur;
            rx_y     <= y_cnt;
            rx_r     <= vga.red;
            rx_g     <= vga.green;
            rx_b     <= vga.blue;

            frame_done <= vs_edge;
            if (vs_edge) begin
                frame_checksum <= sum_nxt;
                active_lines   <= lines_nxt;
                frame_count    <= frame_count + 16'd1;
            end

            err_hlen   <= err_hlen | hlen_bad;
            err_vlen   <= err_vlen | vlen_bad;
            err_active <= err_active | wid_bad | cnt_bad;
        end
    end
endmodule

// File: tb/tb_vga_sink_monitor.sv
// Bench for vga_sink_monitor in a reduced video mode, with a
// frame-level reference model and per-cycle output comparison.
module tb_vga_sink_monitor;
    localparam int HA   = 8;
    localparam int VA   = 6;
    localparam int HT   = 14;
    localparam int VT   = 9;
    localparam int HS_C = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid;
    logic [10:0] rx_x;
    logic [10:0] rx_y;
    logic [7:0]  rx_r;
    logic [7:0]  rx_g;
    logic [7:0]  rx_b;
    logic        frame_done;
    logic [15:0] frame_checksum;
    logic [10:0] active_lines;
    logic [15:0] frame_count;
    logic        locked;
    logic        err_hlen;
    logic        err_vlen;
    logic        err_active;

    always #5 clk = ~clk;

    vga_sink_monitor_if vif();

    vga_sink_monitor #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0)
    ) dut (
        .sys_clock(clk), .rst(rst), .vga(vif),
        .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y),
        .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
        .frame_done(frame_done), .frame_checksum(frame_checksum),
        .active_lines(active_lines), .frame_count(frame_count),
        .locked(locked), .err_hlen(err_hlen), .err_vlen(err_vlen),
        .err_active(err_active)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          cyc = 0;
    int          last_hs;
    bit          have_hs;
    int          lines_since_vs;
    int          edges_since;
    bit          m_eh, m_ev, m_ea;
    logic [15:0] m_fc;
    bit          fr_trust;
    bit          cs_known;
    logic [15:0] m_cs;
    logic [10:0] m_al;
    logic [15:0] f_sum;
    int          f_lines;
    bit          p_hs, p_vs, p_vo;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r_in, input bit hs, input bit vs,
                        input bit vo, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b,
                        input int c, input int l, input int wid);
        bit          hs_e, vs_e, vo_f, act, hb, vb, ab, bad, xy;
        int          lines;
        logic [15:0] pix;
        logic [15:0] cs_now;
        int          al_now;
        logic        e_valid;
        logic [10:0] e_x, e_y;
        logic [7:0]  e_r, e_g, e_b;
        bit          e_done;

        rst          = r_in;
        vif.hsync    = ~hs;
        vif.vsync    = ~vs;
        vif.video_on = vo;
        vif.red      = r;
        vif.green    = g;
        vif.blue     = b;

        pix = 16'(r) + 16'(g) + 16'(b);
        xy  = 1'b0;
        if (r_in) begin
            have_hs = 0; lines_since_vs = 0; edges_since = 0;
            m_eh = 0; m_ev = 0; m_ea = 0; m_fc = 16'd0;
            fr_trust = 0; cs_known = 1; m_cs = 16'd0; m_al = 11'd0;
            f_sum = 16'd0; f_lines = 0;
            e_valid = 0; e_x = 0; e_y = 0;
            e_r = 0; e_g = 0; e_b = 0; e_done = 0;
            xy = 1'b1;
        end else begin
            hs_e = hs && !p_hs;
            vs_e = vs && !p_vs;
            vo_f = !vo && p_vo;
            act  = (edges_since >= 1);
            hb   = hs_e && have_hs && ((cyc - last_hs) != HT);
            lines = lines_since_vs + (hs_e ? 1 : 0);
            vb   = vs_e && (lines != VT);
            cs_now = f_sum + (vo ? pix : 16'd0);
            al_now = f_lines + (vo_f ? 1 : 0);
            ab   = (vo_f && wid != HA) || (vs_e && al_now != VA);
            bad  = act && (hb || vb || ab);
            if (act) begin
                m_eh |= hb;
                m_ev |= vb;
                m_ea |= ab;
            end
            if (bad)
                edges_since = 0;
            else if (vs_e && edges_since < 3)
                edges_since++;

            e_valid = vo;
            e_r = r; e_g = g; e_b = b;
            e_x = 11'(c); e_y = 11'(l);
            xy  = vo && fr_trust;
            e_done = vs_e;

            if (vs_e) begin
                m_fc++;
                cs_known = fr_trust;
                if (fr_trust) begin
                    m_cs = cs_now;
                    m_al = 11'(al_now);
                end
                fr_trust = 1;
                f_sum = 16'd0;
                f_lines = 0;
                lines_since_vs = 0;
            end else begin
                f_sum = cs_now;
                f_lines = al_now;
                lines_since_vs = lines;
            end
            if (hs_e) begin
                last_hs = cyc;
                have_hs = 1;
            end
        end
        p_hs = hs; p_vs = vs; p_vo = vo;

        @(posedge clk);
        #1;
        chk("rx_valid", 32'(rx_valid), 32'(e_valid));
        chk("rx_r", 32'(rx_r), 32'(e_r));
        chk("rx_g", 32'(rx_g), 32'(e_g));
        chk("rx_b", 32'(rx_b), 32'(e_b));
        if (xy) begin
            chk("rx_x", 32'(rx_x), 32'(e_x));
            chk("rx_y", 32'(rx_y), 32'(e_y));
        end
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        if (cs_known) begin
            chk("frame_checksum", 32'(frame_checksum), 32'(m_cs));
            chk("active_lines", 32'(active_lines), 32'(m_al));
        end
        chk("locked", 32'(locked), 32'(edges_since >= 3));
        chk("err_hlen", 32'(err_hlen), 32'(m_eh));
        chk("err_vlen", 32'(err_vlen), 32'(m_ev));
        chk("err_active", 32'(err_active), 32'(m_ea));
        cyc++;
    endtask

    // One frame: nl lines, vsync starting at column vs_col of line nl-2.
    // short_l: line made one cycle short; act_l: line with one pixel less;
    // rst_l: line where rst is pulsed in the back porch.
    task automatic frame(input int nl, input int vs_col, input int short_l,
                         input int act_l, input int rst_l, input bit rnd);
        int          len, wid;
        bit          vo, hs, vs;
        logic [7:0]  r, g, b;
        logic [23:0] rv;
        for (int l = 0; l < nl; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            wid = (l < VA) ? ((l == act_l) ? HA - 1 : HA) : 0;
            for (int c = 0; c < len; c++) begin
                vo = (c < wid);
                hs = (c == HS_C) || (c == HS_C + 1);
                vs = (l == nl - 2 && c >= vs_col) || (l == nl - 1 && c < vs_col);
                r = 8'd0; g = 8'd0; b = 8'd0;
                if (vo && rnd) begin
                    rv = 24'($urandom);
                    r = rv[23:16]; g = rv[15:8]; b = rv[7:0];
                end else if (vo && c == 5 && l == 3) begin
                    r = 8'h10; g = 8'h20; b = 8'h30;
                end
                step(l == rst_l && c == HT - 2, hs, vs, vo, r, g, b, c, l, wid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            step(1'b1, 0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
        fr_trust = 1;

        // Nominal stream with a single lit pixel at (5,3)
        for (int f = 0; f < 4; f++)
            frame(VT, 0, -1, -1, -1, 1'b0);
        chk("tp_frame_count", 32'(frame_count), 32'd4);
        chk("tp_checksum", 32'(frame_checksum), 32'h0060);
        chk("tp_active_lines", 32'(active_lines), 32'(VA));
        chk("tp_locked", 32'(locked), 32'd1);
        chk("tp_no_err", 32'({err_hlen, err_vlen, err_active}), 32'd0);

        // Short line after lock
        frame(VT, 0, 4, -1, -1, 1'b0);
        for (int f = 0; f < 3; f++)
            frame(VT, 0, -1, -1, -1, 1'b0);
        chk("tp_hlen_sticky", 32'(err_hlen), 32'd1);
        chk("tp_hlen_relock", 32'(locked), 32'd1);

        // Frame one line short
        frame(VT - 1, 0, -1, -1, -1, 1'b0);
        chk("tp_vlen", 32'(err_vlen), 32'd1);
        chk("tp_vlen_unlock", 32'(locked), 32'd0);
        for (int f = 0; f < 3; f++)
            frame(VT, 0, -1, -1, -1, 1'b0);

        // One active line one pixel narrow
        frame(VT, 0, -1, 3, -1, 1'b0);
        chk("tp_active", 32'(err_active), 32'd1);
        chk("tp_active_lines_kept", 32'(active_lines), 32'(VA));
        for (int f = 0; f < 3; f++)
            frame(VT, 0, -1, -1, -1, 1'b0);

        // Mid-frame reset, then coincident hsync/vsync with random pixels
        frame(VT, HS_C, -1, -1, 2, 1'b1);
        for (int f = 0; f < 4; f++)
            frame(VT, HS_C, -1, -1, -1, 1'b1);
        chk("tp_coinc_locked", 32'(locked), 32'd1);
        chk("tp_coinc_vlen", 32'(err_vlen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sink_monitor.md
# vga_sink_monitor

Passive receiver for the VESA video stream the game drives to the panel: it consumes hsync/vsync/video_on/RGB on sys_clock and recovers the pixel coordinates. It also checks line and frame timing against the 1024x768 mode, accumulates a per-frame pixel checksum and reports lock status. It sits beside the top level as a self-check and capture endpoint and never drives the VGA pins.

## Interface
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- H_TOTAL, 1328, sys_clock cycles per line
- V_TOTAL, 806, lines per frame
- HS_ACTIVE, 0, asserted level of hsync
- VS_ACTIVE, 0, asserted level of vsync

Ports:
- sys_clock  in  1  system (pixel) clock; inputs are synchronous to it
- rst  in  1  synchronous, active-high reset
- hsync, vsync, video_on  in  1 each  video timing from the sync generator
- red, green, blue  in  8 each  pixel colour
- rx_valid  out  1  registered copy of video_on
- rx_x, rx_y  out  11 each  recovered coordinate of the pixel on rx_r/g/b
- rx_r, rx_g, rx_b  out  8 each  registered pixel colour
- frame_done  out  1  one-cycle pulse at each vsync leading edge
- frame_checksum  out  16  checksum of the completed frame, latched on frame_done
- active_lines  out  11  active lines counted in the completed frame, latched on frame_done
- frame_count  out  16  frame_done pulses since reset, wrapping
- locked  out  1  timing verified
- err_hlen, err_vlen, err_active  out  1 each  sticky error flags

## Operation
- Leading edge: the input is at its active level this cycle and was not at it in the previous cycle. The previous value is kept in a register.
- State machine:
  - SEARCH (reset state): no checks run. The first vsync leading edge moves the block to MEASURE.
  - MEASURE: checks run. At each vsync leading edge, an error-free frame increments good_frames (2 bits, saturating). When good_frames reaches 2, the block moves to LOCKED.
  - LOCKED: checks run.
  - Any error detected in MEASURE or LOCKED returns the block to SEARCH and clears good_frames.
- locked = (state == LOCKED).
- h_period counts sys_clock cycles between hsync leading edges.
  - At an hsync leading edge, a mismatch sets err_hlen if the value is not H_TOTAL and a previous hsync edge exists.
  - The counter then restarts.
- v_lines counts hsync leading edges since the last vsync edge.
  - An hsync edge that coincides with the vsync edge counts toward the ending frame.
  - At the vsync edge, v_lines != V_TOTAL sets err_vlen. The counter then restarts.
- Coordinate recovery:
  - rx_x is 0 on the first video_on cycle of a line and increments on each further video_on cycle.
  - On the video_on falling edge, err_active is set if the line width is not H_ACTIVE, and the line counter increments.
  - rx_y equals the number of completed active lines in the current frame.
- Checksum: accumulate (red + green + blue) zero-extended, added modulo 2^16 on every video_on cycle.
- At a vsync edge:
  - err_active is set if the active line count is not V_ACTIVE.
  - The checksum and line count are latched to the outputs.
  - The accumulators are zeroed.
- All error flags are sticky until rst. err_active is evaluated only in MEASURE or LOCKED.
- rx_x and rx_y saturate at 2047. There is no wrap.

## Timing
- All outputs are registered. Reset value of every output is 0 (state = SEARCH).
- Latency:
  - An input sample in cycle N appears on rx_* in cycle N+1.
  - When the vsync leading edge is sampled in cycle N, frame_done, frame_checksum, active_lines and frame_count update in cycle N+1.
- Error flags and locked update in the cycle after the offending edge. locked falls in the same cycle the error flag rises.
- With nominal timing, locked rises one cycle after the third vsync leading edge following reset.
- rst asserted mid-frame clears all outputs and counters on the next edge. The block resynchronises from SEARCH, and the partial frame is ignored.

## Test plan
- Nominal stream, 4 frames, all pixels black except (5,3) = (0x10,0x20,0x30) -> one rx_valid beat with rx_x=5, rx_y=3, frame_checksum=0x0060, active_lines=768, frame_count=4, locked high after the 3rd vsync, all errors 0.
- After lock, one line of 1327 cycles -> err_hlen=1 and locked=0 one cycle after the next hsync edge; locked returns 3 vsync edges later, err_hlen stays 1.
- After lock, one frame of 805 lines -> err_vlen=1 at that vsync edge, locked=0.
- After lock, line 100 with video_on for 1023 cycles -> err_active=1, locked=0, active_lines still 768.
- rst pulsed mid-frame 200 -> next cycle all outputs 0; locked high again after 3 nominal vsync edges, no errors.
- Coincident hsync/vsync edges with nominal timing -> err_vlen stays 0 (the coincident line is counted in the ending frame).
